// File: rtl/letter_blit_pkg.sv
// Shared constants, state type and atlas-origin helper for the letter blitter.
// Glyph layout follows the letter atlas ROM: 8 glyph columns by 5 glyph rows.
package letter_pkg;

  localparam int unsigned NUM_LETTERS = 40;
  localparam int unsigned GLYPH_W_DEF = 15;
  localparam int unsigned GLYPH_H_DEF = 16;

  localparam int unsigned ROW_OFF [5] = '{0, 17, 32, 49, 65};
  localparam int unsigned COL_OFF [8] = '{0, 14, 28, 40, 56, 72, 84, 98};

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  // Atlas address of a glyph's top-left pixel; rows past the table fold to 0.
  function automatic int unsigned glyph_origin(input logic [5:0] letter,
                                               input int unsigned atlas_w);
    int unsigned row;
    row = 32'(letter[5:3]);
    if (row >= 5) row = 0;
    return ROW_OFF[row] * atlas_w + COL_OFF[letter[2:0]];
  endfunction

endpackage

// File: rtl/letter_blit_glyph_raster_counter.sv
// Raster walker over a GLYPH_W x GLYPH_H cell, gx fastest; wraps to (0,0)
// after the last pixel and exposes first/last pixel flags.
module glyph_raster_counter
  import letter_pkg::*;
#(
  parameter int unsigned GLYPH_W = GLYPH_W_DEF,
  parameter int unsigned GLYPH_H = GLYPH_H_DEF,
  localparam int unsigned GX_W = $clog2(GLYPH_W),
  localparam int unsigned GY_W = $clog2(GLYPH_H)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [GX_W-1:0] gx_o,
  output logic [GY_W-1:0] gy_o,
  output logic            first_o,
  output logic            last_o
);

  logic [GX_W-1:0] gx_q, gx_d;
  logic [GY_W-1:0] gy_q, gy_d;
  logic            gx_end, gy_end;

  assign gx_end = (gx_q == GX_W'(GLYPH_W - 1));
  assign gy_end = (gy_q == GY_W'(GLYPH_H - 1));

  always_comb begin
    gx_d = gx_q;
    gy_d = gy_q;
    if (clr_i) begin
      gx_d = '0;
      gy_d = '0;
    end else if (en_i) begin
      if (gx_end) begin
        gx_d = '0;
        gy_d = gy_end ? '0 : gy_q + GY_W'(1);
      end else begin
        gx_d = gx_q + GX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gx_q <= '0;
      gy_q <= '0;
    end else begin
      gx_q <= gx_d;
      gy_q <= gy_d;
    end
  end

  assign gx_o    = gx_q;
  assign gy_o    = gy_q;
  assign first_o = (gx_q == '0) && (gy_q == '0);
  assign last_o  = gx_end && gy_end;

endmodule

// File: rtl/letter_blit.sv
// Copies one glyph from the 1-bit letter atlas ROM into the 1-bit framebuffer.
// Build option LETTER_BLIT_TRANSPARENT_EN: skip atlas-0 pixels (overlay mode).
module letter_blit
  import letter_pkg::*;
#(
  parameter int unsigned ATLAS_W = 119,
  parameter int unsigned ATLAS_H = 82,
  parameter int unsigned GLYPH_W = GLYPH_W_DEF,
  parameter int unsigned GLYPH_H = GLYPH_H_DEF,
  parameter int unsigned FB_W    = 320,
  parameter int unsigned FB_H    = 180,
  localparam int unsigned ATLAS_AW = $clog2(ATLAS_W * ATLAS_H),
  localparam int unsigned FB_AW    = $clog2(FB_W * FB_H)
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  input  logic                req_valid_in,
  output logic                req_ready_out,
  input  logic [5:0]          letter_in,
  input  logic [10:0]         dst_x_in,
  input  logic [9:0]          dst_y_in,
  output logic [ATLAS_AW-1:0] atlas_addr_out,
  input  logic                atlas_data_in,
  output logic [FB_AW-1:0]    fb_addr_out,
  output logic                fb_data_out,
  output logic                fb_we_out,
  output logic                busy_out,
  output logic                done_out,
  output logic [1:0]          error_out
);

  localparam int unsigned GX_W = $clog2(GLYPH_W);
  localparam int unsigned GY_W = $clog2(GLYPH_H);

  state_e          state_q, state_d;
  logic            drain_q, drain_d;
  logic [5:0]      letter_q;
  logic [10:0]     dst_x_q;
  logic [9:0]      dst_y_q;
  logic [1:0]      err_q, err_d;
  logic            accept, read_en, illegal;
  logic [GX_W-1:0] gx;
  logic [GY_W-1:0] gy;
  logic            last, first_unused;
  logic [11:0]     dx0, dy0, dx1_q, dy1_q, dx2_q, dy2_q;
  logic            inb0, inb1_q, inb2_q, vld1_q, vld2_q;

  assign accept  = (state_q == IDLE) && req_valid_in;
  assign read_en = (state_q == READ);
  assign illegal = (letter_in >= 6'(NUM_LETTERS));

  glyph_raster_counter #(
    .GLYPH_W(GLYPH_W),
    .GLYPH_H(GLYPH_H)
  ) u_raster (
    .clk_i  (pixel_clk_in),
    .rst_ni (rst_n_in),
    .clr_i  (accept),
    .en_i   (read_en),
    .gx_o   (gx),
    .gy_o   (gy),
    .first_o(first_unused),
    .last_o (last)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      drain_q  <= 1'b0;
      err_q    <= '0;
      letter_q <= '0;
      dst_x_q  <= '0;
      dst_y_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      if (accept) begin
        letter_q <= letter_in;
        dst_x_q  <= dst_x_in;
        dst_y_q  <= dst_y_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = (state_q == DRAIN) && !drain_q;
    unique case (state_q)
      IDLE:    if (req_valid_in) state_d = illegal ? DONE : READ;
      READ:    if (last) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_out  = (state_q == IDLE);
    busy_out       = (state_q != IDLE);
    done_out       = (state_q == DONE);
    atlas_addr_out = '0;
    if (state_q == READ)
      atlas_addr_out = ATLAS_AW'(glyph_origin(letter_q, ATLAS_W)
                                 + 32'(gy) * ATLAS_W + 32'(gx));
  end

  // Destination coordinates travel two stages to line up with ROM data.
  assign dx0  = 12'(dst_x_q) + 12'(gx);
  assign dy0  = 12'(dst_y_q) + 12'(gy);
  assign inb0 = (dx0 < 12'(FB_W)) && (dy0 < 12'(FB_H));

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
      inb1_q <= 1'b0;
      inb2_q <= 1'b0;
      dx1_q  <= '0;
      dy1_q  <= '0;
      dx2_q  <= '0;
      dy2_q  <= '0;
    end else begin
      vld1_q <= read_en;
      vld2_q <= vld1_q;
      inb1_q <= inb0;
      inb2_q <= inb1_q;
      dx1_q  <= dx0;
      dy1_q  <= dy0;
      dx2_q  <= dx1_q;
      dy2_q  <= dy1_q;
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept)
      err_d = {1'b0, illegal};
    else if (vld2_q && !inb2_q)
      err_d[1] = 1'b1;
  end

  always_comb begin
`ifdef LETTER_BLIT_TRANSPARENT_EN
    fb_we_out   = vld2_q && inb2_q && atlas_data_in;
    fb_data_out = fb_we_out;
`else
    fb_we_out   = vld2_q && inb2_q;
    fb_data_out = fb_we_out && atlas_data_in;
`endif
    fb_addr_out = '0;
    if (fb_we_out)
      fb_addr_out = FB_AW'(32'(dy2_q) * FB_W + 32'(dx2_q));
  end

  assign error_out = err_q;

endmodule

// File: tb/tb_letter_blit.sv
// Scoreboard bench for letter_blit: a random atlas ROM with 2-cycle latency
// feeds the DUT, and expected framebuffer writes are queued per request.
module tb_letter_blit;

  typedef struct {
    int unsigned addr;
    bit          data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  letter;
  logic [10:0] dst_x;
  logic [9:0]  dst_y;
  logic [13:0] atlas_addr;
  logic        atlas_data;
  logic [15:0] fb_addr;
  logic        fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;
  logic [1:0]  error;

  logic        mem [0:9757];
  logic        rom_q1, rom_q2;
  wr_t         sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          row_t [5] = '{0, 17, 32, 49, 65};
  int          col_t [8] = '{0, 14, 28, 40, 56, 72, 84, 98};

  letter_blit dut (
    .pixel_clk_in  (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_ready_out (req_ready),
    .letter_in     (letter),
    .dst_x_in      (dst_x),
    .dst_y_in      (dst_y),
    .atlas_addr_out(atlas_addr),
    .atlas_data_in (atlas_data),
    .fb_addr_out   (fb_addr),
    .fb_data_out   (fb_data),
    .fb_we_out     (fb_we),
    .busy_out      (busy),
    .done_out      (done),
    .error_out     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q1 <= mem[atlas_addr];
    rom_q2 <= rom_q1;
  end
  assign atlas_data = rom_q2;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int atlas_idx(input int l, input int gx, input int gy);
    return (row_t[l / 8] + gy) * 119 + col_t[l % 8] + gx;
  endfunction

  task automatic drive(input int l, input int x, input int y);
    letter    = 6'(l);
    dst_x     = 11'(x);
    dst_y     = 10'(y);
    req_valid = 1'b1;
  endtask

  task automatic expect_glyph(input int l, input int x, input int y, output int n);
    wr_t e;
    n = 0;
    if (l < 40) begin
      for (int gy = 0; gy < 16; gy++) begin
        for (int gx = 0; gx < 15; gx++) begin
          if (x + gx < 320 && y + gy < 180) begin
            e.addr = (y + gy) * 320 + x + gx;
`ifdef LETTER_BLIT_TRANSPARENT_EN
            e.data = 1'b1;
            if (mem[atlas_idx(l, gx, gy)]) begin
              sb.push_back(e);
              n++;
            end
`else
            e.data = mem[atlas_idx(l, gx, gy)];
            sb.push_back(e);
            n++;
`endif
          end
        end
      end
    end
  endtask

  task automatic accept_req(output int waited);
    bit got = 1'b0;
    waited = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (req_ready) begin
        waited = i;
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_job(input int l, input int exp_n, input logic [1:0] exp_err,
                            input int exp_lat, input bit drop_valid, output int first_fb);
    int  nwr = 0;
    int  fw = 0;
    int  lat = 0;
    int  maxa = 0;
    wr_t e;
    first_fb = -1;
    if (drop_valid) req_valid = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (l < 40 && k <= 240)
        check("atlas_addr", atlas_addr, atlas_idx(l, (k - 1) % 15, (k - 1) / 15));
      if (fb_we) begin
        nwr++;
        if (fw == 0) begin
          fw = k;
          first_fb = int'(fb_addr);
        end
        if (int'(fb_addr) > maxa) maxa = int'(fb_addr);
        if (sb.size() == 0) check("extra_write", nwr, exp_n);
        else begin
          e = sb.pop_front();
          check("fb_addr", fb_addr, e.addr);
          check("fb_data", fb_data, e.data);
        end
      end
      if (done) begin
        lat = k;
        check("busy_at_done", busy, 1);
        check("ready_at_done", req_ready, 0);
        check("error_out", error, exp_err);
        break;
      end
    end
    check("done_latency", lat, exp_lat);
    check("write_count", nwr, exp_n);
    check("sb_left", sb.size(), 0);
    check("fb_addr_in_range", maxa < 57600, 1);
`ifndef LETTER_BLIT_TRANSPARENT_EN
    if (exp_n > 0) check("first_write_latency", fw, 3);
`endif
    if (drop_valid) begin
      @(negedge clk);
      check("done_cleared", done, 0);
      check("ready_after_done", req_ready, 1);
      check("busy_after_done", busy, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, n2, w, ff, nwr;
    wr_t e;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    letter    = '0;
    dst_x     = '0;
    dst_y     = '0;
    for (int i = 0; i < 9758; i++) mem[i] = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", fb_we, 0);
    check("rst_error", error, 0);
    check("rst_atlas_addr", atlas_addr, 0);
    check("rst_fb_addr", fb_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Origin glyph at the framebuffer origin.
    drive(0, 0, 0);
    expect_glyph(0, 0, 0, n);
    accept_req(w);
    finish_job(0, n, 2'b00, 243, 1'b1, ff);

    // Interior placement, second atlas row.
    drive(9, 100, 50);
    expect_glyph(9, 100, 50, n);
    accept_req(w);
    finish_job(9, n, 2'b00, 243, 1'b1, ff);
`ifndef LETTER_BLIT_TRANSPARENT_EN
    check("first_fb_addr_l9", ff, 16100);
`endif

    // Illegal letter: straight to DONE, no traffic.
    drive(45, 10, 10);
    expect_glyph(45, 10, 10, n);
    accept_req(w);
    finish_job(45, n, 2'b01, 1, 1'b1, ff);

    // Bottom-right corner clip: 10x10 visible.
    drive(3, 310, 170);
    expect_glyph(3, 310, 170, n);
    accept_req(w);
    finish_job(3, n, 2'b10, 243, 1'b1, ff);
`ifndef LETTER_BLIT_TRANSPARENT_EN
    check("clip_count", n, 100);
`endif

    // Asynchronous reset in the middle of a clipped glyph.
    drive(5, 310, 20);
    expect_glyph(5, 310, 20, n);
    accept_req(w);
    req_valid = 1'b0;
    nwr = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (fb_we) begin
        nwr++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pre_rst_fb_addr", fb_addr, e.addr);
        end
        if (nwr == 57) break;
      end
    end
    check("writes_before_reset", nwr, 57);
    check("err_before_reset", error, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", fb_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_error", error, 0);
    check("mid_rst_atlas_addr", atlas_addr, 0);
    sb.delete();
    nwr = 0;
    repeat (4) begin
      @(negedge clk);
      if (fb_we) nwr++;
    end
    check("writes_in_reset", nwr, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle_we", fb_we, 0);

    drive(1, 0, 0);
    expect_glyph(1, 0, 0, n);
    accept_req(w);
    finish_job(1, n, 2'b00, 243, 1'b1, ff);

    // Back-to-back with valid held high through the first job.
    drive(20, 200, 100);
    expect_glyph(20, 200, 100, n);
    accept_req(w);
    drive(39, 5, 170);
    finish_job(20, n, 2'b00, 243, 1'b0, ff);
    expect_glyph(39, 5, 170, n2);
    accept_req(w);
    check("b2b_accept_gap", w, 1);
    finish_job(39, n2, 2'b10, 243, 1'b1, ff);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
